// File: rtl/cdb_arbiter.sv
// cdb_arbiter: common-data-bus arbiter. Each producer owns a small FIFO of
// completed results {rob_idx, value}. Every cycle the FIFO heads that are
// oldest relative to rob_head are broadcast on up to NUM_LANES registered
// CDB lanes. Lanes are packed from lane 0, and a source wins at most one lane.
module cdb_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int NUM_LANES = 2,
  parameter int DATA_W    = 16,
  parameter int IDX_W     = 4,
  parameter int QDEPTH    = 2,
  localparam int SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [IDX_W-1:0]               rob_head,
  input  logic [NUM_SRC-1:0]             src_valid,
  input  logic [NUM_SRC*IDX_W-1:0]       src_idx,
  input  logic [NUM_SRC*DATA_W-1:0]      src_value,
  output logic [NUM_SRC-1:0]             src_ready,
  output logic [NUM_LANES-1:0]           cdb_valid,
  output logic [NUM_LANES*IDX_W-1:0]     cdb_idx,
  output logic [NUM_LANES*DATA_W-1:0]    cdb_value,
  output logic [NUM_LANES*SRC_W-1:0]     cdb_src
);

  localparam int PTR_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W  = $clog2(QDEPTH + 1);
  localparam int RANK_W = $clog2(NUM_SRC + 1);

  // Advance a FIFO pointer, wrapping at QDEPTH (also correct for QDEPTH == 1).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(QDEPTH - 1)) begin
      ptr_inc = {PTR_W{1'b0}};
    end else begin
      ptr_inc = ptr + PTR_W'(1);
    end
  endfunction

  // Per-source FIFO state
  logic [IDX_W-1:0]  fifo_idx_r [NUM_SRC][QDEPTH];
  logic [DATA_W-1:0] fifo_val_r [NUM_SRC][QDEPTH];
  logic [PTR_W-1:0]  rd_ptr_r   [NUM_SRC];
  logic [PTR_W-1:0]  wr_ptr_r   [NUM_SRC];
  logic [CNT_W-1:0]  count_r    [NUM_SRC];
  logic [CNT_W-1:0]  count_next_s [NUM_SRC];
  logic [NUM_SRC-1:0] ready_r;

  // Arbitration signals
  logic [NUM_SRC-1:0] push_s;
  logic [NUM_SRC-1:0] pop_s;
  logic [NUM_SRC-1:0] cand_s;
  logic [IDX_W-1:0]   head_idx_s [NUM_SRC];
  logic [DATA_W-1:0]  head_val_s [NUM_SRC];
  logic [IDX_W-1:0]   age_s      [NUM_SRC];
  logic [RANK_W-1:0]  rank_s     [NUM_SRC];
  logic [NUM_SRC-1:0] hit_s      [NUM_LANES];

  logic [NUM_LANES-1:0]        lane_valid_s;
  logic [NUM_LANES*IDX_W-1:0]  lane_idx_s;
  logic [NUM_LANES*DATA_W-1:0] lane_val_s;
  logic [NUM_LANES*SRC_W-1:0]  lane_src_s;

  // Registered CDB lanes
  logic [NUM_LANES-1:0]        cdb_valid_r;
  logic [NUM_LANES*IDX_W-1:0]  cdb_idx_r;
  logic [NUM_LANES*DATA_W-1:0] cdb_value_r;
  logic [NUM_LANES*SRC_W-1:0]  cdb_src_r;

  assign src_ready = ready_r;
  assign cdb_valid = cdb_valid_r;
  assign cdb_idx   = cdb_idx_r;
  assign cdb_value = cdb_value_r;
  assign cdb_src   = cdb_src_r;

  // Heads, ages (modulo ROB size) and age rank of every non-empty FIFO.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      head_idx_s[i] = fifo_idx_r[i][rd_ptr_r[i]];
      head_val_s[i] = fifo_val_r[i][rd_ptr_r[i]];
      cand_s[i]     = (count_r[i] != {CNT_W{1'b0}});
      age_s[i]      = head_idx_s[i] - rob_head;
      push_s[i]     = src_valid[i] & ready_r[i];
    end
    for (int i = 0; i < NUM_SRC; i++) begin
      rank_s[i] = {RANK_W{1'b0}};
      for (int j = 0; j < NUM_SRC; j++) begin
        // j beats i when older, or equally old with a lower source index
        rank_s[i] = rank_s[i] + RANK_W'(cand_s[j] &&
                    ((age_s[j] < age_s[i]) || ((age_s[j] == age_s[i]) && (j < i))));
      end
      pop_s[i] = cand_s[i] && (rank_s[i] < RANK_W'(NUM_LANES));
    end
  end

  // Route the candidate of rank l onto lane l; ranks are dense, so lanes pack from 0.
  always_comb begin
    lane_valid_s = {NUM_LANES{1'b0}};
    lane_idx_s   = {(NUM_LANES*IDX_W){1'b0}};
    lane_val_s   = {(NUM_LANES*DATA_W){1'b0}};
    lane_src_s   = {(NUM_LANES*SRC_W){1'b0}};
    for (int l = 0; l < NUM_LANES; l++) begin
      hit_s[l] = {NUM_SRC{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
        hit_s[l][i] = cand_s[i] && (rank_s[i] == RANK_W'(l));
        lane_valid_s[l] = lane_valid_s[l] | hit_s[l][i];
        lane_idx_s[l*IDX_W +: IDX_W] = lane_idx_s[l*IDX_W +: IDX_W] |
                                       ({IDX_W{hit_s[l][i]}} & head_idx_s[i]);
        lane_val_s[l*DATA_W +: DATA_W] = lane_val_s[l*DATA_W +: DATA_W] |
                                         ({DATA_W{hit_s[l][i]}} & head_val_s[i]);
        lane_src_s[l*SRC_W +: SRC_W] = lane_src_s[l*SRC_W +: SRC_W] |
                                       ({SRC_W{hit_s[l][i]}} & SRC_W'(i));
      end
    end
  end

  // Next occupancy per FIFO: a push and a pop together leave the count unchanged.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      case ({push_s[i], pop_s[i]})
        2'b10:   count_next_s[i] = count_r[i] + CNT_W'(1);
        2'b01:   count_next_s[i] = count_r[i] - CNT_W'(1);
        default: count_next_s[i] = count_r[i];
      endcase
    end
  end

  // FIFO data storage; only pointers/counts need reset since empty FIFOs are never read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!flush && push_s[i]) begin
        fifo_idx_r[i][wr_ptr_r[i]] <= src_idx[i*IDX_W +: IDX_W];
        fifo_val_r[i][wr_ptr_r[i]] <= src_value[i*DATA_W +: DATA_W];
      end
    end
  end

  // FIFO control, ready flags and CDB lane registers; flush overrides push and pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        count_r[i]  <= {CNT_W{1'b0}};
      end
      ready_r     <= {NUM_SRC{1'b1}};
      cdb_valid_r <= {NUM_LANES{1'b0}};
      cdb_idx_r   <= {(NUM_LANES*IDX_W){1'b0}};
      cdb_value_r <= {(NUM_LANES*DATA_W){1'b0}};
      cdb_src_r   <= {(NUM_LANES*SRC_W){1'b0}};
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_ptr_r[i] <= {PTR_W{1'b0}};
        wr_ptr_r[i] <= {PTR_W{1'b0}};
        count_r[i]  <= {CNT_W{1'b0}};
      end
      ready_r     <= {NUM_SRC{1'b1}};
      cdb_valid_r <= {NUM_LANES{1'b0}};
      cdb_idx_r   <= {(NUM_LANES*IDX_W){1'b0}};
      cdb_value_r <= {(NUM_LANES*DATA_W){1'b0}};
      cdb_src_r   <= {(NUM_LANES*SRC_W){1'b0}};
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= ptr_inc(wr_ptr_r[i]);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= ptr_inc(rd_ptr_r[i]);
        end
        count_r[i] <= count_next_s[i];
        ready_r[i] <= (count_next_s[i] < CNT_W'(QDEPTH));
      end
      cdb_valid_r <= lane_valid_s;
      cdb_idx_r   <= lane_idx_s;
      cdb_value_r <= lane_val_s;
      cdb_src_r   <= lane_src_s;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed scenarios and random traffic on a default
// instance, plus a random sweep on a 6-source / 3-lane / 5-bit-index instance.
// A queue-based reference model predicts every lane and every ready flag.
module tb_cdb_arbiter;

  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic        a_flush;
  logic [3:0]  a_head;
  logic [3:0]  a_valid;
  logic [15:0] a_idx;
  logic [63:0] a_value;
  logic [3:0]  a_ready;
  logic [1:0]  a_cv;
  logic [7:0]  a_ci;
  logic [31:0] a_cval;
  logic [3:0]  a_cs;

  // Instance B: 6 sources, 3 lanes, 5-bit ROB index
  logic        b_flush;
  logic [4:0]  b_head;
  logic [5:0]  b_valid;
  logic [29:0] b_idx;
  logic [95:0] b_value;
  logic [5:0]  b_ready;
  logic [2:0]  b_cv;
  logic [14:0] b_ci;
  logic [47:0] b_cval;
  logic [8:0]  b_cs;

  cdb_arbiter dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .rob_head(a_head),
    .src_valid(a_valid), .src_idx(a_idx), .src_value(a_value), .src_ready(a_ready),
    .cdb_valid(a_cv), .cdb_idx(a_ci), .cdb_value(a_cval), .cdb_src(a_cs)
  );

  cdb_arbiter #(.NUM_SRC(6), .NUM_LANES(3), .IDX_W(5)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .rob_head(b_head),
    .src_valid(b_valid), .src_idx(b_idx), .src_value(b_value), .src_ready(b_ready),
    .cdb_valid(b_cv), .cdb_idx(b_ci), .cdb_value(b_cval), .cdb_src(b_cs)
  );

  int checks = 0;
  int failures = 0;

  // Count one comparison and report it if it does not match.
  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Active configuration: which instance is driven and its shape
  int sel, ns, nl, iw;

  // Stimulus for the current cycle
  int st_valid[6];
  int st_idx[6];
  int st_val[6];
  int st_head;
  bit st_flush;

  // Reference model: one queue of pending results per source
  int mq_idx[6][$];
  int mq_val[6][$];

  // Observed outputs
  int ob_v[3], ob_i[3], ob_d[3], ob_s[3], ob_r[6];

  task automatic clear_stim();
    for (int i = 0; i < 6; i++) st_valid[i] = 0;
    st_flush = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 6; i++) begin
      mq_idx[i].delete();
      mq_val[i].delete();
    end
  endtask

  task automatic apply();
    a_valid = '0; b_valid = '0; a_flush = 1'b0; b_flush = 1'b0;
    a_idx = '0; a_value = '0; b_idx = '0; b_value = '0;
    a_head = st_head[3:0];
    b_head = st_head[4:0];
    for (int i = 0; i < 6; i++) begin
      if (sel == 0 && i < 4) begin
        a_valid[i] = st_valid[i][0];
        a_idx[i*4 +: 4] = st_idx[i][3:0];
        a_value[i*16 +: 16] = st_val[i][15:0];
      end
      if (sel == 1) begin
        b_valid[i] = st_valid[i][0];
        b_idx[i*5 +: 5] = st_idx[i][4:0];
        b_value[i*16 +: 16] = st_val[i][15:0];
      end
    end
    if (sel == 0) a_flush = st_flush; else b_flush = st_flush;
  endtask

  task automatic observe();
    for (int l = 0; l < 3; l++) begin
      ob_v[l] = 0; ob_i[l] = 0; ob_d[l] = 0; ob_s[l] = 0;
    end
    for (int i = 0; i < 6; i++) ob_r[i] = 0;
    if (sel == 0) begin
      for (int l = 0; l < 2; l++) begin
        ob_v[l] = int'(a_cv[l]);
        ob_i[l] = int'(a_ci[l*4 +: 4]);
        ob_d[l] = int'(a_cval[l*16 +: 16]);
        ob_s[l] = int'(a_cs[l*2 +: 2]);
      end
      for (int i = 0; i < 4; i++) ob_r[i] = int'(a_ready[i]);
    end else begin
      for (int l = 0; l < 3; l++) begin
        ob_v[l] = int'(b_cv[l]);
        ob_i[l] = int'(b_ci[l*5 +: 5]);
        ob_d[l] = int'(b_cval[l*16 +: 16]);
        ob_s[l] = int'(b_cs[l*3 +: 3]);
      end
      for (int i = 0; i < 6; i++) ob_r[i] = int'(b_ready[i]);
    end
  endtask

  // One clock: predict lanes from the queues, advance the model, compare after the edge.
  task automatic tick(input string tag);
    int ev[3], ei[3], ed[3], es[3];
    bit used[6];
    bit acc[6];
    int best, bage, age, rsz;
    apply();
    for (int l = 0; l < 3; l++) begin
      ev[l] = 0; ei[l] = 0; ed[l] = 0; es[l] = 0;
    end
    for (int i = 0; i < 6; i++) begin
      used[i] = 1'b0; acc[i] = 1'b0;
    end
    if (st_flush) begin
      clear_model();
    end else begin
      for (int i = 0; i < ns; i++) acc[i] = (st_valid[i] != 0) && (mq_idx[i].size() < QD);
      for (int l = 0; l < nl; l++) begin
        best = -1; bage = 0;
        for (int i = 0; i < ns; i++) begin
          if (mq_idx[i].size() > 0 && !used[i]) begin
            age = (mq_idx[i][0] - st_head + (1 << iw)) % (1 << iw);
            if (best < 0 || age < bage) begin
              best = i; bage = age;
            end
          end
        end
        if (best >= 0) begin
          ev[l] = 1; ei[l] = mq_idx[best][0]; ed[l] = mq_val[best][0]; es[l] = best;
          used[best] = 1'b1;
        end
      end
      for (int i = 0; i < ns; i++) begin
        if (used[i]) begin
          void'(mq_idx[i].pop_front());
          void'(mq_val[i].pop_front());
        end
        if (acc[i]) begin
          mq_idx[i].push_back(st_idx[i] % (1 << iw));
          mq_val[i].push_back(st_val[i] % 65536);
        end
      end
    end
    @(posedge clk);
    #1;
    observe();
    for (int l = 0; l < nl; l++) begin
      check_eq($sformatf("%s_l%0d_valid", tag, l), ob_v[l], ev[l]);
      if (ev[l] != 0) begin
        check_eq($sformatf("%s_l%0d_idx", tag, l), ob_i[l], ei[l]);
        check_eq($sformatf("%s_l%0d_value", tag, l), ob_d[l], ed[l]);
        check_eq($sformatf("%s_l%0d_src", tag, l), ob_s[l], es[l]);
      end
    end
    for (int i = 0; i < ns; i++) begin
      rsz = (mq_idx[i].size() < QD) ? 1 : 0;
      check_eq($sformatf("%s_ready%0d", tag, i), ob_r[i], rsz);
    end
  endtask

  task automatic random_phase(input int cycles, input int flush_pct);
    for (int c = 0; c < cycles; c++) begin
      for (int i = 0; i < ns; i++) begin
        st_valid[i] = ($urandom_range(99) < 60) ? 1 : 0;
        st_idx[i]   = int'($urandom_range((1 << iw) - 1));
        st_val[i]   = int'($urandom_range(65535));
      end
      st_head  = int'($urandom_range((1 << iw) - 1));
      st_flush = ($urandom_range(99) < flush_pct) ? 1'b1 : 1'b0;
      tick($sformatf("rnd%0d_c%0d", sel, c));
    end
    clear_stim();
    for (int c = 0; c < 4; c++) tick($sformatf("drain%0d_c%0d", sel, c));
  endtask

  initial begin
    sel = 0; ns = 4; nl = 2; iw = 4;
    rst = 1'b1;
    st_head = 0;
    clear_stim();
    for (int i = 0; i < 6; i++) begin
      st_idx[i] = 0; st_val[i] = 0;
    end
    apply();
    #12;
    check_eq("reset_cdb_valid_a", int'(a_cv), 0);
    check_eq("reset_cdb_idx_a", int'(a_ci), 0);
    check_eq("reset_ready_a", int'(a_ready), 15);
    check_eq("reset_ready_b", int'(b_ready), 63);
    check_eq("reset_cdb_valid_b", int'(b_cv), 0);
    @(negedge clk);
    rst = 1'b0;

    // Age ordering across the ROB wrap point
    st_head = 14;
    for (int i = 0; i < 4; i++) begin
      st_valid[i] = 1; st_val[i] = 100 + i;
    end
    st_idx[0] = 3; st_idx[1] = 15; st_idx[2] = 1; st_idx[3] = 14;
    tick("wrap_push");
    clear_stim();
    tick("wrap_c1");
    check_eq("wrap_c1_l0_idx", ob_i[0], 14);
    check_eq("wrap_c1_l0_src", ob_s[0], 3);
    check_eq("wrap_c1_l1_idx", ob_i[1], 15);
    check_eq("wrap_c1_l1_src", ob_s[1], 1);
    tick("wrap_c2");
    check_eq("wrap_c2_l0_idx", ob_i[0], 1);
    check_eq("wrap_c2_l0_src", ob_s[0], 2);
    check_eq("wrap_c2_l1_idx", ob_i[1], 3);
    check_eq("wrap_c2_l1_src", ob_s[1], 0);
    tick("wrap_idle");
    check_eq("wrap_idle_valid", ob_v[0] + ob_v[1], 0);

    // Per-source order: one source streaming back-to-back
    st_head = 0;
    for (int k = 0; k < 3; k++) begin
      st_valid[0] = 1; st_idx[0] = 5 + k; st_val[0] = 200 + k;
      tick($sformatf("order_k%0d", k));
      check_eq($sformatf("order_k%0d_ready0", k), ob_r[0], 1);
      if (k > 0) begin
        check_eq($sformatf("order_k%0d_l0_idx", k), ob_i[0], 4 + k);
        check_eq($sformatf("order_k%0d_l1_valid", k), ob_v[1], 0);
      end
    end
    clear_stim();
    tick("order_last");
    check_eq("order_last_l0_idx", ob_i[0], 7);
    tick("order_idle");

    // Full FIFO: source 0 holds the youngest entries and backs up
    for (int i = 0; i < 4; i++) begin
      st_valid[i] = 1; st_val[i] = 300 + i;
    end
    st_idx[0] = 12; st_idx[1] = 1; st_idx[2] = 3; st_idx[3] = 5;
    tick("full_c1");
    for (int i = 0; i < 4; i++) st_val[i] = 310 + i;
    st_idx[0] = 13; st_idx[1] = 2; st_idx[2] = 4; st_idx[3] = 6;
    tick("full_c2");
    check_eq("full_c2_ready0", ob_r[0], 0);
    clear_stim();
    st_valid[0] = 1; st_idx[0] = 14; st_val[0] = 999;
    tick("full_c3");
    check_eq("full_c3_ready0", ob_r[0], 0);
    tick("full_c4");
    check_eq("full_c4_l1_idx", ob_i[1], 12);
    check_eq("full_c4_ready0", ob_r[0], 1);
    st_val[0] = 555;
    tick("full_c5");
    st_idx[0] = 15; st_val[0] = 556;
    tick("full_c6");
    check_eq("full_c6_ready0", ob_r[0], 1);
    clear_stim();
    for (int c = 0; c < 3; c++) tick($sformatf("full_drain%0d", c));

    // Flush drops queued and same-cycle pushes
    for (int i = 0; i < 3; i++) begin
      st_valid[i] = 1; st_idx[i] = 2 + i; st_val[i] = 400 + i;
    end
    tick("flush_fill");
    clear_stim();
    st_flush = 1'b1;
    st_valid[0] = 1; st_idx[0] = 8; st_val[0] = 410;
    st_valid[3] = 1; st_idx[3] = 9; st_val[3] = 411;
    tick("flush_edge");
    check_eq("flush_edge_valid", int'(a_cv), 0);
    clear_stim();
    st_valid[3] = 1; st_idx[3] = 10; st_val[3] = 420;
    tick("flush_push");
    check_eq("flush_push_valid", int'(a_cv), 0);
    clear_stim();
    tick("flush_after");
    check_eq("flush_after_l0_idx", ob_i[0], 10);
    check_eq("flush_after_l0_src", ob_s[0], 3);
    tick("flush_idle");

    // Asynchronous reset with results still queued
    for (int i = 0; i < 4; i++) begin
      st_valid[i] = 1; st_idx[i] = 1 + i; st_val[i] = 500 + i;
    end
    tick("rst_fill");
    clear_stim();
    tick("rst_c1");
    rst = 1'b1;
    #1;
    check_eq("rst_mid_valid", int'(a_cv), 0);
    check_eq("rst_mid_ready", int'(a_ready), 15);
    clear_model();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) tick($sformatf("rst_idle%0d", c));

    // Random traffic on the default instance
    random_phase(300, 3);

    // Parameter sweep instance
    sel = 1; ns = 6; nl = 3; iw = 5;
    st_head = 0;
    clear_stim();
    tick("sweep_start");
    random_phase(600, 2);
    check_eq("sweep_ready_all", int'(b_ready), 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
